// File: rtl/iaq_chan_sched.sv
// iaq_chan_sched
// Round-robin scheduler that lets NCH ADPCM decoder channels share one inverse
// adaptive quantizer. The granted channel's I/Y/RATE are registered onto the
// shared quantizer inputs. After DQ_LAT cycles the result D is captured and
// returned to the requester, together with a one-cycle ack.
//
// Optional build macro: IAQ_RATE_MASK_EN
//   When it is defined, q_I is loaded with the granted code masked to the
//   valid width for its RATE. When it is undefined, q_I is loaded with the
//   code unmodified.
module iaq_chan_sched #(
   parameter int NCH    = 4,
   parameter int CHW    = 2,
   parameter int DQ_LAT = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               scan_in0,
   input  logic               scan_en,
   output logic               scan_out0,
   input  logic [NCH-1:0]     req,
   input  logic [5*NCH-1:0]   i_bus,
   input  logic [13*NCH-1:0]  y_bus,
   input  logic [2*NCH-1:0]   rate_bus,
   output logic [4:0]         q_I,
   output logic [12:0]        q_Y,
   output logic [1:0]         q_RATE,
   input  logic [15:0]        q_D,
   output logic [15:0]        d_out,
   output logic [CHW-1:0]     d_ch,
   output logic               d_valid,
   output logic [NCH-1:0]     ack,
   output logic               busy
);

   localparam int CNTW = 3;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state;
   logic [CNTW-1:0]   cnt;
   logic [CHW-1:0]    last;
   logic [NCH-1:0]    eligible;
   logic              grant_hi_found;
   logic              grant_lo_found;
   logic [CHW-1:0]    grant_hi;
   logic [CHW-1:0]    grant_lo;
   logic              grant_found;
   logic [CHW-1:0]    grant;
   logic [4:0]        sel_i;
   logic [12:0]       sel_y;
   logic [1:0]        sel_rate;
   logic [4:0]        load_i;
   logic              unused_scan;

   // The scan pins are stitched during synthesis, so the RTL only ties the chain output low.
   assign scan_out0   = 1'b0;
   assign unused_scan = scan_in0 ^ scan_en;

   // The channel that is acked in this cycle must wait one cycle before it is considered again.
   assign eligible = req & ~ack;

   // Round-robin search. The lowest eligible channel above last wins; otherwise the lowest eligible channel at or below last wins.
   always_comb begin
      grant_hi_found = 1'b0;
      grant_lo_found = 1'b0;
      grant_hi       = '0;
      grant_lo       = '0;
      for (int j = NCH - 1; j >= 0; j--) begin
         if (eligible[j]) begin
            if (j > int'(last)) begin
               grant_hi_found = 1'b1;
               grant_hi       = CHW'(j);
            end else begin
               grant_lo_found = 1'b1;
               grant_lo       = CHW'(j);
            end
         end
      end
   end

   assign grant_found = grant_hi_found | grant_lo_found;
   assign grant       = grant_hi_found ? grant_hi : grant_lo;

   // Select the granted channel's slice from each of the packed input buses.
   always_comb begin
      sel_i    = '0;
      sel_y    = '0;
      sel_rate = '0;
      for (int j = 0; j < NCH; j++) begin
         if (grant == CHW'(j)) begin
            sel_i    = i_bus[5*j +: 5];
            sel_y    = y_bus[13*j +: 13];
            sel_rate = rate_bus[2*j +: 2];
         end
      end
   end

`ifdef IAQ_RATE_MASK_EN
   // Clear the code bits that do not exist at the granted channel's rate.
   always_comb begin
      load_i = sel_i;
      case (sel_rate)
         2'b00:   load_i = {1'b0, sel_i[3:0]};
         2'b01:   load_i = {2'b00, sel_i[2:0]};
         2'b10:   load_i = {3'b000, sel_i[1:0]};
         default: load_i = sel_i;
      endcase
   end
`else
   assign load_i = sel_i;
`endif

   // Scheduler FSM. In IDLE it grants a channel and loads the quantizer inputs. In WAIT it counts out the quantizer latency and then returns D.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         last    <= CHW'(NCH - 1);
         q_I     <= '0;
         q_Y     <= '0;
         q_RATE  <= '0;
         d_out   <= '0;
         d_ch    <= '0;
         d_valid <= 1'b0;
         ack     <= '0;
         busy    <= 1'b0;
      end else begin
         d_valid <= 1'b0;
         ack     <= '0;
         case (state)
            IDLE: begin
               if (grant_found) begin
                  q_I    <= load_i;
                  q_Y    <= sel_y;
                  q_RATE <= sel_rate;
                  last   <= grant;
                  cnt    <= CNTW'(DQ_LAT);
                  busy   <= 1'b1;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  d_out   <= q_D;
                  d_ch    <= last;
                  d_valid <= 1'b1;
                  ack     <= NCH'(1) << last;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
